// File: rtl/keypad_pkg.sv
// Shared key codes, scanner FSM states and the row/column to key-code map.
// Latency: none (types and a pure function only).
// Backpressure: none.
package keypad_pkg;

   localparam logic [3:0] KEY_NONE = 4'd0;
   localparam logic [3:0] KEY_ZERO = 4'd10;
   localparam logic [3:0] KEY_STAR = 4'd11;
   localparam logic [3:0] KEY_HASH = 4'd12;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } kp_state_e;

   // Row-major keypad: rows 0..2 carry digits 1..9, row 3 is '*', '0', '#'.
   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      if (row == 2'd3) begin
         case (col)
            2'd0:    code = KEY_STAR;
            2'd1:    code = KEY_ZERO;
            default: code = KEY_HASH;
         endcase
      end else begin
         code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous keypad row lines.
// Latency: 2 clocks from d_i to q_o.
// Backpressure: none; samples every clock.
module keypad_sync #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // Two back-to-back flops; the first may go metastable, the second is used.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x3 keypad scanner: column drive, frame-level debounce, held key code plus strobe (auto-repeat under KEYPAD_REPEAT_EN).
// Latency: key_data/key_valid registered one clock after the frame-end sample; press accepted after DEBOUNCE_FRAMES equal frames.
// Backpressure: none; key_valid is a one-cycle strobe the consumer must take when it fires.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 24999,
   parameter int DEBOUNCE_FRAMES = 20,
   parameter int REPEAT_FRAMES   = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_row,
   output logic [2:0] key_col,
   output logic [3:0] key_data,
   output logic       key_valid
);

   localparam int               DIV_W   = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV);
   localparam logic [7:0]       DB_MAX  = 8'(DEBOUNCE_FRAMES);

   if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 255 ||
       REPEAT_FRAMES < 1 || REPEAT_FRAMES > 255) begin : g_bad_param
      $error("keypad_scan: DEBOUNCE_FRAMES and REPEAT_FRAMES must be 1..255");
   end

   // ------------------------------------------------------------------
   // Row synchronizer
   // ------------------------------------------------------------------
   logic [3:0] row_s;

   keypad_sync #(.W(4)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (key_row),
      .q_o (row_s)
   );

   // ------------------------------------------------------------------
   // Column divider and ring
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] div_q;
   logic [2:0]       col_q;
   logic [1:0]       col_idx;
   logic             dwell_end;
   logic             frame_end;

   assign dwell_end = (div_q == DIV_MAX);
   assign col_idx   = col_q[2] ? 2'd2 : (col_q[1] ? 2'd1 : 2'd0);
   assign frame_end = dwell_end && (col_idx == 2'd2);

   // Count out each column dwell, then rotate the one-hot column drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         col_q <= 3'b001;
      end else if (dwell_end) begin
         div_q <= '0;
         col_q <= {col_q[1:0], col_q[2]};
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Frame encoder: accumulate hits over three dwells, reject ghosts
   // ------------------------------------------------------------------
   logic [1:0] hits_q, hits_d;          // saturates at 2: "two or more"
   logic [3:0] acc_code_q, acc_code_d;
   logic [2:0] row_cnt;
   logic [1:0] row_idx;
   logic [2:0] tot_hits;
   logic [3:0] tot_code;
   logic [3:0] frame_code;

   // Fold this dwell's row sample into the running frame hit count and code.
   always_comb begin
      row_cnt = 3'(row_s[0]) + 3'(row_s[1]) + 3'(row_s[2]) + 3'(row_s[3]);
      row_idx = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (row_s[r]) row_idx = 2'(r);
      end
      tot_hits   = {1'b0, hits_q} + row_cnt;
      tot_code   = (row_cnt == 3'd1) ? key_code(row_idx, col_idx) : acc_code_q;
      frame_code = (frame_end && tot_hits == 3'd1) ? tot_code : KEY_NONE;
      hits_d     = hits_q;
      acc_code_d = acc_code_q;
      if (frame_end) begin
         hits_d     = '0;
         acc_code_d = KEY_NONE;
      end else if (dwell_end) begin
         hits_d     = (tot_hits > 3'd2) ? 2'd2 : tot_hits[1:0];
         acc_code_d = tot_code;
      end
   end

   // Hold the partial-frame accumulation between dwells.
   always_ff @(posedge clk) begin
      if (rst) begin
         hits_q     <= '0;
         acc_code_q <= KEY_NONE;
      end else begin
         hits_q     <= hits_d;
         acc_code_q <= acc_code_d;
      end
   end

   // ------------------------------------------------------------------
   // Debounce FSM
   // ------------------------------------------------------------------
   kp_state_e  state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] cand_q, cand_d;
   logic [3:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       accept;
   logic       rel_done;
   logic       rep_fire;

   // State, debounce counter and press candidate.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cand_q  <= KEY_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
      end
   end

   // Transitions happen only at frame end; a held key must fully release before another is taken.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cand_d   = cand_q;
      accept   = 1'b0;
      rel_done = 1'b0;
      if (frame_end) begin
         case (state_q)
            IDLE: begin
               if (frame_code != KEY_NONE) begin
                  cand_d = frame_code;
                  if (DB_MAX == 8'd1) begin
                     accept  = 1'b1;
                     cnt_d   = '0;
                     state_d = HELD;
                  end else begin
                     cnt_d   = 8'd1;
                     state_d = PRESS_DB;
                  end
               end
            end
            PRESS_DB: begin
               if (frame_code == cand_q) begin
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_d == DB_MAX) begin
                     accept  = 1'b1;
                     cnt_d   = '0;
                     state_d = HELD;
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
            HELD: begin
               if (frame_code != data_q) begin
                  if (DB_MAX == 8'd1) begin
                     rel_done = 1'b1;
                     cnt_d    = '0;
                     state_d  = IDLE;
                  end else begin
                     cnt_d   = 8'd1;
                     state_d = REL_DB;
                  end
               end
            end
            REL_DB: begin
               if (frame_code != data_q) begin
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_d == DB_MAX) begin
                     rel_done = 1'b1;
                     cnt_d    = '0;
                     state_d  = IDLE;
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = HELD;
               end
            end
         endcase
      end
   end

`ifdef KEYPAD_REPEAT_EN
   localparam logic [7:0] REP_MAX = 8'(REPEAT_FRAMES);
   logic [7:0] rep_q, rep_d;

   // Count steady HELD frames; a bounce through REL_DB pauses rather than restarts the count.
   always_comb begin
      rep_d    = rep_q;
      rep_fire = 1'b0;
      if (accept) begin
         rep_d = '0;
      end else if (frame_end && state_q == HELD && frame_code == data_q) begin
         if (rep_q + 8'd1 == REP_MAX) begin
            rep_d    = '0;
            rep_fire = 1'b1;
         end else begin
            rep_d = rep_q + 8'd1;
         end
      end
   end

   // Repeat frame counter.
   always_ff @(posedge clk) begin
      if (rst) rep_q <= '0;
      else     rep_q <= rep_d;
   end
`else
   assign rep_fire = 1'b0;
`endif

   // Output decode: new code with strobe on accept, silent clear on release, bare strobe on repeat.
   always_comb begin
      data_d  = data_q;
      valid_d = accept | rep_fire;
      if (accept) begin
         data_d = (state_q == IDLE) ? frame_code : cand_q;
      end else if (rel_done) begin
         data_d = KEY_NONE;
      end
   end

   // Registered key outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= KEY_NONE;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign key_col   = col_q;
   assign key_data  = data_q;
   assign key_valid = valid_q;

endmodule
